// File: rtl/gpio_pkg.sv
// Shared types and constants for the APB-to-GPIO register sequencer.
// Holds the FSM state encoding, GPIO register selects and APB offsets.
package gpio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic [1:0] REGSEL_PIN  = 2'b00;
  localparam logic [1:0] REGSEL_DIR  = 2'b10;
  localparam logic [1:0] REGSEL_PORT = 2'b11;

  localparam logic [3:0] OFF_PIN  = 4'h0;
  localparam logic [3:0] OFF_DIR  = 4'h4;
  localparam logic [3:0] OFF_PORT = 4'h8;

endpackage

// File: rtl/gpio_apb_decode.sv
// Combinational APB address decode: maps the low address nibble to a GPIO
// register select and flags accesses the GPIO cannot accept.
module gpio_apb_decode
  import gpio_pkg::*;
(
  input  logic [3:0] paddr,
  input  logic       pwrite,
  output logic [1:0] regsel,
  output logic       illegal
);

  always_comb begin
    regsel  = REGSEL_PIN;
    illegal = 1'b0;
    case (paddr)
      OFF_PIN: begin
        regsel  = REGSEL_PIN;
        illegal = pwrite;  // PIN is read-only
      end
      OFF_DIR:  regsel = REGSEL_DIR;
      OFF_PORT: regsel = REGSEL_PORT;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/gpio_apb_ctrl.sv
// APB slave sequencer for one GPIO: turns APB transfers into a one-cycle
// write strobe or a two-cycle registered read, with PSLVERR on illegal access.
//
// APB handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0)
// seen in IDLE; the master then holds PSEL/PENABLE/PADDR/PWDATA stable until
// PREADY, which is high for exactly one cycle together with PSLVERR/PRDATA.
module gpio_apb_ctrl
  import gpio_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              BUSW,
  output logic [7:0]        BUSWDATA,
  output logic [1:0]        REGSEL,
  input  logic [7:0]        BUSRDATA,
  output logic [2:0]        dbg_state
);

  state_e     state_q, state_d;
  logic [7:0] prdata_q, prdata_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic       busw_q, busw_d;
  logic [7:0] buswdata_q, buswdata_d;
  logic [1:0] regsel_q, regsel_d;
  logic       err_q, err_d;

  logic [1:0] dec_regsel;
  logic       dec_illegal;
  logic       unused_paddr;

  // Upper address bits are decoded by the interconnect through PSEL.
  assign unused_paddr = ^PADDR;

  gpio_apb_decode u_decode (
    .paddr   (PADDR[3:0]),
    .pwrite  (PWRITE),
    .regsel  (dec_regsel),
    .illegal (dec_illegal)
  );

  // Outputs are computed for the state being entered so they are registered.
  always_comb begin
    state_d    = state_q;
    prdata_d   = prdata_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    busw_d     = 1'b0;
    buswdata_d = buswdata_q;
    regsel_d   = regsel_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        regsel_d = REGSEL_PIN;
        if (PSEL && !PENABLE) begin
          prdata_d = 8'h00;
          err_d    = dec_illegal;
          if (dec_illegal) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (PWRITE) begin
            state_d    = ST_WR;
            busw_d     = 1'b1;
            regsel_d   = dec_regsel;
            buswdata_d = PWDATA;
          end else begin
            state_d  = ST_RD1;
            regsel_d = dec_regsel;
          end
        end
      end
      ST_WR: begin
        state_d   = ST_RESP;
        pready_d  = 1'b1;
        pslverr_d = err_q;
      end
      ST_RD1: begin
        state_d = ST_RD2;
      end
      ST_RD2: begin
        // The GPIO registered its read data at the end of RD1.
        state_d   = ST_RESP;
        prdata_d  = BUSRDATA;
        pready_d  = 1'b1;
        pslverr_d = err_q;
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        regsel_d = REGSEL_PIN;
      end
      default: begin
        state_d  = ST_IDLE;
        regsel_d = REGSEL_PIN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prdata_q   <= 8'h00;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      busw_q     <= 1'b0;
      buswdata_q <= 8'h00;
      regsel_q   <= REGSEL_PIN;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      busw_q     <= busw_d;
      buswdata_q <= buswdata_d;
      regsel_q   <= regsel_d;
      err_q      <= err_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign BUSW      = busw_q;
  assign BUSWDATA  = buswdata_q;
  assign REGSEL    = regsel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// Bench for gpio_apb_ctrl: an APB driver pushes expected responses into a
// scoreboard, a negedge monitor pops and compares; a small GPIO model answers.
module tb_gpio_apb_ctrl;
  import gpio_pkg::*;

  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [7:0]    pwdata = 8'h00;
  logic [7:0]    prdata, buswdata, busrdata;
  logic          pready, pslverr, busw;
  logic [1:0]    regsel;
  logic [2:0]    dbg_state;

  gpio_apb_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PSEL      (psel),
    .PENABLE   (penable),
    .PWRITE    (pwrite),
    .PADDR     (paddr),
    .PWDATA    (pwdata),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr),
    .BUSW      (busw),
    .BUSWDATA  (buswdata),
    .REGSEL    (regsel),
    .BUSRDATA  (busrdata),
    .dbg_state (dbg_state)
  );

  // ---------------- GPIO peripheral model ----------------
  logic [7:0] g_dir, g_port, g_pin_sync, g_rdata;
  logic [7:0] ext_pins = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      g_dir <= 8'h00; g_port <= 8'h00; g_pin_sync <= 8'h00; g_rdata <= 8'h00;
    end else begin
      g_pin_sync <= (g_dir & g_port) | (~g_dir & ext_pins);
      if (busw) begin
        if (regsel == 2'b10) g_dir <= buswdata;
        else if (regsel == 2'b11) g_port <= buswdata;
      end else begin
        case (regsel)
          2'b00:   g_rdata <= g_pin_sync;
          2'b10:   g_rdata <= g_dir;
          2'b11:   g_rdata <= g_port;
          default: g_rdata <= 8'h00;
        endcase
      end
    end
  end
  assign busrdata = g_rdata;

  // ---------------- reference model ----------------
  logic [7:0] ref_dir = 8'h00, ref_port = 8'h00;

  function automatic logic [7:0] ref_read(input logic [3:0] a);
    if (a == 4'h4) return ref_dir;
    if (a == 4'h8) return ref_port;
    return (ref_dir & ref_port) | (~ref_dir & ext_pins);
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [12:0] exp_q[$];   // {latency[3:0], pslverr, prdata[7:0]}
  int unsigned setup_q[$];
  logic [41:0] wexp_q[$];  // {busw cycle[31:0], regsel[1:0], data[7:0]}

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    logic [41:0] w;
    int unsigned s;
    if (pready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pready", 32'(pready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        s = setup_q.pop_front();
        chk("pslverr", 32'(pslverr), 32'(e[8]));
        chk("prdata", 32'(prdata), 32'(e[7:0]));
        chk("latency", cyc - s, 32'(e[12:9]));
      end
    end else begin
      chk("pslverr_without_pready", 32'(pslverr), 32'd0);
    end
    if (busw) begin
      if (wexp_q.size() == 0) begin
        chk("unexpected_busw", 32'(busw), 32'd0);
      end else begin
        w = wexp_q.pop_front();
        chk("busw_cycle", cyc, w[41:10]);
        chk("busw_regsel", 32'(regsel), 32'(w[9:8]));
        chk("busw_data", 32'(buswdata), 32'(w[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [7:0] d);
    logic legal;
    logic [1:0] rs;
    logic [3:0] hi;
    bit done;
    legal = (a == 4'h0 && !wr) || a == 4'h4 || a == 4'h8;
    rs = (a == 4'h4) ? 2'b10 : 2'b11;
    if (!legal) begin
      exp_q.push_back({4'd1, 1'b1, 8'h00});
    end else if (wr) begin
      exp_q.push_back({4'd2, 1'b0, 8'h00});
      wexp_q.push_back({cyc + 1, rs, d});
      if (a == 4'h4) ref_dir = d; else ref_port = d;
    end else begin
      exp_q.push_back({4'd3, 1'b0, ref_read(a)});
    end
    setup_q.push_back(cyc);
    hi = 4'($urandom_range(0, 15));
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {hi, a}; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (pready) done = 1'b1;
    end
    if (!done) chk("pready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_prdata"}, 32'(prdata), 32'd0);
    chk({tag, "_pready"}, 32'(pready), 32'd0);
    chk({tag, "_pslverr"}, 32'(pslverr), 32'd0);
    chk({tag, "_busw"}, 32'(busw), 32'd0);
    chk({tag, "_buswdata"}, 32'(buswdata), 32'd0);
    chk({tag, "_regsel"}, 32'(regsel), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Read that is cut off by reset during RD2; no response is expected.
  task automatic read_abort(input logic [3:0] a);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {4'h0, a};
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    psel = 1'b0; penable = 1'b0;
    ref_dir = 8'h00; ref_port = 8'h00;
    @(negedge clk);
    check_reset_outputs("abort_reset");
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [3:0] a;
    logic [7:0] d;
    idle(3);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    apb_xfer(1'b1, 4'h4, 8'hA5);
    apb_xfer(1'b1, 4'h8, 8'h3C);
    apb_xfer(1'b0, 4'h8, 8'h00);
    apb_xfer(1'b0, 4'h4, 8'h00);

    ext_pins = 8'h5A;
    apb_xfer(1'b1, 4'h4, 8'h00);
    idle(2);
    apb_xfer(1'b0, 4'h0, 8'h00);

    apb_xfer(1'b1, 4'h0, 8'hFF);
    apb_xfer(1'b0, 4'hC, 8'h00);
    apb_xfer(1'b0, 4'h6, 8'h00);
    apb_xfer(1'b1, 4'h5, 8'h11);
    apb_xfer(1'b0, 4'h4, 8'h00);
    apb_xfer(1'b0, 4'h8, 8'h00);

    // PSEL with PENABLE but no setup cycle must be ignored.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_setup_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("no_setup_pready", 32'(pready), 32'd0);
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    apb_xfer(1'b0, 4'h4, 8'h00);

    idle(3);
    @(negedge clk);
    chk("prdata_hold", 32'(prdata), 32'h00);
    apb_xfer(1'b0, 4'h8, 8'h00);
    idle(3);
    @(negedge clk);
    chk("prdata_hold", 32'(prdata), 32'h3C);
    @(posedge clk); #1;

    apb_xfer(1'b1, 4'h4, 8'h77);
    read_abort(4'h4);
    apb_xfer(1'b0, 4'h4, 8'h00);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: a = 4'h0;
        1: a = 4'h4;
        2: a = 4'h8;
        3: a = 4'hC;
        default: a = 4'($urandom_range(0, 15));
      endcase
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        ext_pins = 8'($urandom_range(0, 255));
        idle(2);
      end
      apb_xfer(1'($urandom_range(0, 1)), a, d);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(4);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("wexp_q_empty", 32'(wexp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gpio_apb_ctrl.md
# gpio_apb_ctrl

APB slave-side controller that sequences register accesses to one GPIO instance. It decodes APB transfers, generates the GPIO's one-cycle `BUSW` write strobe and `REGSEL`, and accounts for the GPIO's registered read path by inserting wait states. It reports illegal accesses with `PSLVERR`. It sits between the APB interconnect and the GPIO, in the same clock domain.

## Interface
- `ADDR_W`, default 4: APB address width. Only `PADDR[3:0]` is decoded; upper bits are ignored (base decode happens in the interconnect via `PSEL`).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `PSEL`  in  1  APB select.
- `PENABLE`  in  1  APB access phase.
- `PWRITE`  in  1  1 = write.
- `PADDR`  in  ADDR_W  byte address.
- `PWDATA`  in  8  write data.
- `PRDATA`  out  8  read data (registered).
- `PREADY`  out  1  transfer complete.
- `PSLVERR`  out  1  error response, valid only with `PREADY`.
- `BUSW`  out  1  GPIO write strobe.
- `BUSWDATA`  out  8  GPIO write data.
- `REGSEL`  out  2  GPIO register select: 00 = PIN, 10 = DIR, 11 = PORT.
- `BUSRDATA`  in  8  GPIO read data; registered inside the GPIO, so it is valid one edge after `REGSEL` is presented with `BUSW`=0.

## Operation
- Address map (`PADDR[3:0]`):
  - 0x0: PIN, read-only.
  - 0x4: DIR, R/W.
  - 0x8: PORT, R/W.
  - 0xC, or any `PADDR[1:0]`≠0: illegal.
- Error cases: writing PIN, or any illegal address. An error transfer makes no GPIO access, and `BUSW` stays 0.
- FSM states: IDLE, WR, RD1, RD2, RESP.
- IDLE:
  - `BUSW`=0 and `REGSEL`=00.
  - On `PSEL`=1 with `PENABLE`=0 (setup phase), latch address, direction and `PWDATA`, and clear `PRDATA` to 0.
  - Then branch: to RESP with err=1 if the access is illegal, else to WR for a write, else to RD1 for a read.
- WR: `BUSW`=1, `REGSEL`=decoded, `BUSWDATA`=latched data, for exactly one cycle, then RESP.
- RD1: `BUSW`=0, `REGSEL`=decoded; the GPIO loads `BUSRDATA` at the end of this cycle. Then RD2.
- RD2: `REGSEL` held; `PRDATA` <= `BUSRDATA` at the end of this cycle. Then RESP.
- RESP:
  - `PREADY`=1 and `PSLVERR`=err, for exactly one cycle.
  - Then IDLE; `REGSEL` returns to 00.
- `PREADY` is asserted only in RESP. `PSLVERR` is 0 outside RESP.
- Master protocol: the master holds `PSEL`/`PENABLE`/address/data stable until `PREADY`. The FSM is non-abortable; deassertion of `PSEL` mid-transfer does not cancel a GPIO access already sequenced.
- In IDLE, `PSEL`=1 with `PENABLE`=1 (no setup seen) is ignored.
- `PRDATA` holds its value after RESP until the next accepted setup. Writes and errors return `PRDATA`=0.

## Timing
- Reset (`rst_n`=0 at an edge): state is IDLE, and `PRDATA`, `PREADY`, `PSLVERR`, `BUSW`, `BUSWDATA`, `REGSEL` are all 0. This applies in any state, including mid-WR/RD; the transfer is dropped and no `PREADY` is issued.
- Cycle 0 is the setup cycle.
- Write: WR in cycle 1, `PREADY` in cycle 2 (1 wait state).
- Read: RD1 in cycle 1, RD2 in cycle 2, `PREADY` with valid `PRDATA` in cycle 3 (2 wait states).
- Error: `PREADY`=1 and `PSLVERR`=1 in cycle 1 (0 wait states).
- Back-to-back transfers: a new setup is accepted in the cycle after RESP. Maximum throughput is one write per 3 cycles and one read per 4 cycles.
- PIN reads return the pin value sampled by the GPIO one clock before RD1 ends.

## Structure
- `gpio_pkg` holds:
  - the FSM state enum;
  - `REGSEL` encodings (`REGSEL_PIN`=2'b00, `REGSEL_DIR`=2'b10, `REGSEL_PORT`=2'b11);
  - address offsets (`OFF_PIN`=4'h0, `OFF_DIR`=4'h4, `OFF_PORT`=4'h8).
- Sub-module `gpio_apb_decode`, combinational: `PADDR[3:0]`, `PWRITE` in; `regsel`, `illegal` out.
- The FSM, latches and output registers live in the top module.

## Test plan
- Write 0xA5 to 0x4 -> cycle 1: `BUSW`=1, `REGSEL`=10, `BUSWDATA`=0xA5; cycle 2: `PREADY`=1, `PSLVERR`=0; `BUSW`=0 in every other cycle.
- Write 0x3C to 0x8, then read 0x8 -> read `PREADY` in cycle 3 with `PRDATA`=0x3C; `REGSEL`=11 during RD1/RD2.
- GPIO DIR=0x00, pins driven 0x5A, read 0x0 -> `PRDATA`=0x5A, `PSLVERR`=0, 2 wait states.
- Write to 0x0, then read 0xC, then read 0x6 -> each gives `PREADY`=`PSLVERR`=1 in cycle 1, `PRDATA`=0, `BUSW` never 1, GPIO DIR/PORT unchanged.
- Assert `rst_n`=0 in RD2 of a read -> the next cycle is IDLE with all outputs 0 and no `PREADY`. A subsequent read of 0x4 completes normally and returns DIR=0x00.
- `PSEL`+`PENABLE` high in IDLE without a setup cycle -> no state change, no GPIO access, `PREADY` stays 0.
